hex_digit_sequencer: RTL and testbench

HEX_DIGIT_SEQUENCER -- requirements
Module: hex_digit_sequencer

---
 rtl/hex_digit_sequencer.sv | 144 ++++++++++++++
 tb/tb_hex_digit_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_digit_sequencer.sv
// Hex digit sequencer: a prescaled step strobe drives a 4-bit up/down/hold
// counter, and two debounced push buttons cycle the count mode and load a
// preset digit. All outputs are registered and feed a 7-segment decoder.
module hex_digit_sequencer #(
   parameter int DIV        = 25_000_000,
   parameter int DEB_CYCLES = 500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_load,
   input  logic [3:0] load_val,
   output logic [3:0] HEX_out,
   output logic       dp_out,
   output logic [1:0] mode_out,
   output logic       step_tick
);

   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_HOLD = 2'b10
   } mode_t;

   // Index 0 is the mode button, index 1 the load button.
   logic [1:0]    raw;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    stable;
   logic [1:0]    press;
   logic [CW-1:0] cnt [2];

   logic          mode_ev;
   logic          load_ev;
   logic [PW-1:0] presc;
   mode_t         mode;
   mode_t         mode_next;

   assign raw     = {btn_load, btn_mode};
   assign mode_ev = press[0];
   assign load_ev = press[1];

   // Synchronize both buttons, debounce them, and emit a one-cycle pulse
   // in the same edge that a debounced level rises, so its effect lands on
   // the following edge. Falling levels update stable silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         press  <= '0;
         for (int i = 0; i < 2; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
               press[i]  <= sync2[i];
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // Prescaler wraps every DIV cycles; a load restarts the period so the
   // loaded digit is shown for a full step interval.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         step_tick <= 1'b0;
      end else begin
         step_tick <= (presc == PRE_MAX);
         if (load_ev || presc == PRE_MAX) begin
            presc <= '0;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   // Mode state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode <= MODE_UP;
      end else begin
         mode <= mode_next;
      end
   end

   // Mode rotation UP -> DOWN -> HOLD -> UP on each mode press.
   always_comb begin
      mode_next = mode;
      if (mode_ev) begin
         case (mode)
            MODE_UP:   mode_next = MODE_DOWN;
            MODE_DOWN: mode_next = MODE_HOLD;
            default:   mode_next = MODE_UP;
         endcase
      end
   end

   assign mode_out = mode;

   // Digit update: a load takes priority over a step; a step uses the mode
   // held before any coincident mode press.
   always_ff @(posedge clk) begin
      if (rst) begin
         HEX_out <= 4'h0;
         dp_out  <= 1'b0;
      end else if (load_ev) begin
         HEX_out <= load_val;
         dp_out  <= 1'b0;
      end else if (step_tick) begin
         case (mode)
            MODE_UP: begin
               HEX_out <= HEX_out + 4'd1;
               dp_out  <= (HEX_out == 4'hF);
            end
            MODE_DOWN: begin
               HEX_out <= HEX_out - 4'd1;
               dp_out  <= (HEX_out == 4'h0);
            end
            default: begin
               HEX_out <= HEX_out;
               dp_out  <= dp_out;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_digit_sequencer.sv
// Bench for hex_digit_sequencer with DIV=4, DEB_CYCLES=3: directed scenarios
// followed by random button activity, compared each cycle with a reference
// model built from the behavioural rules.
module tb_hex_digit_sequencer;

   localparam int DIV = 4;
   localparam int DEB = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_load = 1'b0;
   logic [3:0] load_val = 4'h0;
   logic [3:0] HEX_out;
   logic       dp_out;
   logic [1:0] mode_out;
   logic       step_tick;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state (values after the most recent edge)
   int m_hex, m_dp, m_mode, m_tick, m_phase;
   int m_st[2], m_run[2], m_dl0[2], m_dl1[2], m_pend[2];

   hex_digit_sequencer #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_load  (btn_load),
      .load_val  (load_val),
      .HEX_out   (HEX_out),
      .dp_out    (dp_out),
      .mode_out  (mode_out),
      .step_tick (step_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Advance the model by one rising edge using the inputs present at it.
   task automatic model_edge();
      int raw[2];
      int cur_tick;
      int seen;
      int np;
      if (rst) begin
         m_hex = 0; m_dp = 0; m_mode = 0; m_tick = 0; m_phase = 0;
         for (int b = 0; b < 2; b++) begin
            m_st[b] = 0; m_run[b] = 0; m_dl0[b] = 0; m_dl1[b] = 0; m_pend[b] = 0;
         end
         return;
      end
      raw[0]   = int'(btn_mode);
      raw[1]   = int'(btn_load);
      cur_tick = m_tick;
      m_tick   = (m_phase == DIV - 1) ? 1 : 0;
      if (m_pend[1] != 0) begin
         m_hex   = int'(load_val);
         m_dp    = 0;
         m_phase = 0;
      end else begin
         m_phase = (m_phase + 1) % DIV;
         if (cur_tick != 0 && m_mode == 0) begin
            m_dp  = (m_hex == 15) ? 1 : 0;
            m_hex = (m_hex + 1) % 16;
         end else if (cur_tick != 0 && m_mode == 1) begin
            m_dp  = (m_hex == 0) ? 1 : 0;
            m_hex = (m_hex + 15) % 16;
         end
      end
      if (m_pend[0] != 0) m_mode = (m_mode + 1) % 3;
      // Button accepted after DEB consecutive synchronized samples that
      // disagree with the accepted level; only a rise is an event.
      for (int b = 0; b < 2; b++) begin
         np   = 0;
         seen = m_dl1[b];
         if (seen != m_st[b]) begin
            m_run[b]++;
            if (m_run[b] == DEB) begin
               m_st[b]  = seen;
               m_run[b] = 0;
               np       = seen;
            end
         end else begin
            m_run[b] = 0;
         end
         m_dl1[b]  = m_dl0[b];
         m_dl0[b]  = raw[b];
         m_pend[b] = np;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      chk("hex",  {4'h0, HEX_out},  8'(m_hex));
      chk("dp",   {7'h0, dp_out},   8'(m_dp));
      chk("mode", {6'h0, mode_out}, 8'(m_mode));
      chk("tick", {7'h0, step_tick}, 8'(m_tick));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn_mode = 1'b0;
      btn_load = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic press_mode(input int hold);
      btn_mode = 1'b1;
      for (int i = 0; i < hold; i++) cycle();
      btn_mode = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
   endtask

   initial begin
      int h0, d0;

      // Reset state and free-running count
      do_reset();
      chk("rst_hex",  {4'h0, HEX_out}, 8'd0);
      chk("rst_dp",   {7'h0, dp_out}, 8'd0);
      chk("rst_mode", {6'h0, mode_out}, 8'd0);
      chk("rst_tick", {7'h0, step_tick}, 8'd0);
      for (int i = 1; i <= 70; i++) begin
         cycle();
         if (i == 4)  chk("first_tick", {7'h0, step_tick}, 8'd1);
         if (i == 5)  chk("first_step", {4'h0, HEX_out}, 8'd1);
         if (i == 65) chk("wrap_hex", {4'h0, HEX_out}, 8'd0);
         if (i == 65) chk("wrap_dp",  {7'h0, dp_out}, 8'd1);
         if (i == 69) chk("after_wrap_dp", {7'h0, dp_out}, 8'd0);
      end

      // Mode press right after reset: DOWN at edge 6, then 1,0,F(wrap),E
      do_reset();
      btn_mode = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         cycle();
         if (i == 10) btn_mode = 1'b0;
         if (i == 5)  chk("mode_e5", {6'h0, mode_out}, 8'd0);
         if (i == 6)  chk("mode_e6", {6'h0, mode_out}, 8'd1);
         if (i == 13) chk("down_wrap_hex", {4'h0, HEX_out}, 8'd15);
         if (i == 13) chk("down_wrap_dp",  {7'h0, dp_out}, 8'd1);
         if (i == 17) chk("down_e_hex", {4'h0, HEX_out}, 8'd14);
         if (i == 17) chk("down_e_dp",  {7'h0, dp_out}, 8'd0);
      end

      // Two-cycle glitch: no mode change
      btn_mode = 1'b1;
      cycle();
      cycle();
      btn_mode = 1'b0;
      for (int i = 0; i < 16; i++) cycle();
      chk("glitch_mode", {6'h0, mode_out}, 8'd1);

      // HOLD freezes digit and wrap flag, third press returns to UP
      do_reset();
      for (int i = 0; i < 9; i++) cycle();
      press_mode(6);
      press_mode(6);
      chk("hold_mode", {6'h0, mode_out}, 8'd2);
      h0 = m_hex;
      d0 = m_dp;
      for (int i = 0; i < 12; i++) begin
         cycle();
         chk("hold_hex", {4'h0, HEX_out}, 8'(h0));
         chk("hold_dp",  {7'h0, dp_out}, 8'(d0));
      end
      press_mode(6);
      chk("back_up_mode", {6'h0, mode_out}, 8'd0);

      // Load coinciding with step_tick
      for (int i = 0; i < 8 && m_phase != 3; i++) cycle();
      chk("load_align", 8'(m_phase), 8'd3);
      load_val = 4'hA;
      btn_load = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         cycle();
         if (i == 8)  btn_load = 1'b0;
         if (i == 5)  chk("load_tick_coinc", {7'h0, step_tick}, 8'd1);
         if (i == 6)  chk("load_hex", {4'h0, HEX_out}, 8'd10);
         if (i == 6)  chk("load_dp",  {7'h0, dp_out}, 8'd0);
         if (i == 9)  chk("load_no_early_tick", {7'h0, step_tick}, 8'd0);
         if (i == 10) chk("load_next_tick", {7'h0, step_tick}, 8'd1);
         if (i == 11) chk("load_then_b", {4'h0, HEX_out}, 8'd11);
      end

      // Reset mid-debounce discards the pending press
      do_reset();
      btn_mode = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      rst = 1'b1;
      btn_mode = 1'b0;
      cycle();
      chk("mid_rst_hex",  {4'h0, HEX_out}, 8'd0);
      chk("mid_rst_mode", {6'h0, mode_out}, 8'd0);
      chk("mid_rst_tick", {7'h0, step_tick}, 8'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) cycle();
      chk("mid_rst_no_event", {6'h0, mode_out}, 8'd0);

      // Random button activity
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(5) == 0) btn_mode = ~btn_mode;
         if ($urandom_range(7) == 0) btn_load = ~btn_load;
         if ($urandom_range(15) == 0) load_val = 4'($urandom_range(15));
         rst = ($urandom_range(249) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
